// File: rtl/video_half_scaler.sv
// 2x2 box-average downscaler (2:1 horizontal, 2:1 vertical) for one video channel.
// Define HALF_SCALER_ROUND_EN for round-half-up output; otherwise the average is truncated.
module video_half_scaler #(
    parameter int H_ACTIVE = 1280,
    parameter int LBUF_AW  = 10
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_vtc_vs,
    input  logic        I_vtc_data_valid,
    input  logic [31:0] I_vtc_data,
    output logic        O_vtc_vs,
    output logic        O_vtc_data_valid,
    output logic [31:0] O_vtc_data
);
    localparam int CW = $clog2(H_ACTIVE + 1);

    logic [CW-1:0]      r_col_cnt;
    logic               r_line_par;
    logic               r_de_d;
    logic               r_vs_d;
    logic               r_frame_ok;
    logic               r_discard;
    logic [23:0]        r_pair_hold;
    logic               r_s1_valid;
    logic               r_s1_par;
    logic [LBUF_AW-1:0] r_s1_addr;
    logic [26:0]        r_s1_hsum;
    logic [26:0]        r_lbuf [0:(1<<LBUF_AW)-1];

    logic               w_vs_rise;
    logic               w_de_fall;
    logic               w_accept;
    logic               w_odd_col;
    logic [LBUF_AW-1:0] w_addr;
    logic [26:0]        w_hsum;
    logic [26:0]        w_rd;
    logic [23:0]        w_out;
    logic               w_unused_hi;

    assign w_unused_hi = ^I_vtc_data[31:24];

    assign w_vs_rise = I_vtc_vs & ~r_vs_d;
    assign w_de_fall = ~I_vtc_data_valid & r_de_d;
    // Pixels count only inside a synced frame, outside a vs-aborted line, and below H_ACTIVE.
    assign w_accept  = I_vtc_data_valid & r_frame_ok & ~r_discard & ~w_vs_rise
                     & (r_col_cnt < CW'(H_ACTIVE));
    assign w_odd_col = w_accept & r_col_cnt[0];
    assign w_addr    = LBUF_AW'(r_col_cnt >> 1);
    assign w_rd      = r_lbuf[r_s1_addr];

    always_comb begin
        w_hsum = '0;
        for (int k = 0; k < 3; k++) begin
            w_hsum[k*9 +: 9] = {1'b0, r_pair_hold[k*8 +: 8]} + {1'b0, I_vtc_data[k*8 +: 8]};
        end
    end

    always_comb begin
        w_out = '0;
        for (int k = 0; k < 3; k++) begin
`ifdef HALF_SCALER_ROUND_EN
            w_out[k*8 +: 8] = 8'(({2'b00, w_rd[k*9 +: 9]} + {2'b00, r_s1_hsum[k*9 +: 9]} + 11'd2) >> 2);
`else
            w_out[k*8 +: 8] = 8'(({1'b0, w_rd[k*9 +: 9]} + {1'b0, r_s1_hsum[k*9 +: 9]}) >> 2);
`endif
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_col_cnt        <= '0;
            r_line_par       <= 1'b0;
            r_de_d           <= 1'b0;
            r_vs_d           <= 1'b0;
            r_frame_ok       <= 1'b0;
            r_discard        <= 1'b0;
            r_pair_hold      <= '0;
            r_s1_valid       <= 1'b0;
            r_s1_par         <= 1'b0;
            r_s1_addr        <= '0;
            r_s1_hsum        <= '0;
            O_vtc_vs         <= 1'b0;
            O_vtc_data_valid <= 1'b0;
            O_vtc_data       <= '0;
        end else begin
            r_de_d <= I_vtc_data_valid;
            r_vs_d <= I_vtc_vs;

            // A frame start mid-line drops the rest of that line without advancing parity.
            if (w_vs_rise) begin
                r_frame_ok <= 1'b1;
                r_line_par <= 1'b0;
                r_col_cnt  <= '0;
                r_discard  <= I_vtc_data_valid;
            end else if (w_de_fall) begin
                r_col_cnt <= '0;
                if (r_discard) begin
                    r_discard <= 1'b0;
                end else begin
                    r_line_par <= ~r_line_par;
                end
            end else if (w_accept) begin
                r_col_cnt <= r_col_cnt + CW'(1);
            end

            if (w_accept && !r_col_cnt[0]) begin
                r_pair_hold <= I_vtc_data[23:0];
            end

            r_s1_valid <= w_odd_col;
            if (w_odd_col) begin
                r_s1_hsum <= w_hsum;
                r_s1_par  <= r_line_par;
                r_s1_addr <= w_addr;
            end

            O_vtc_vs         <= r_vs_d;
            O_vtc_data_valid <= r_s1_valid & r_s1_par;
            if (r_s1_valid && r_s1_par) begin
                O_vtc_data <= {8'h00, w_out};
            end
        end
    end

    // Even lines park their horizontal sums here for the following odd line.
    always_ff @(posedge I_clk) begin
        if (r_s1_valid && !r_s1_par) begin
            r_lbuf[r_s1_addr] <= r_s1_hsum;
        end
    end

endmodule

// File: tb/tb_video_half_scaler.sv
// Bench for video_half_scaler: frame-level reference model feeding a scoreboard of expected pixels.
// Build with HALF_SCALER_ROUND_EN defined to match a rounding DUT build.
`timescale 1ns/1ps
module tb_video_half_scaler;
    localparam int H  = 64;
    localparam int AW = 5;

    logic        I_clk = 1'b0;
    logic        I_rst;
    logic        I_vtc_vs;
    logic        I_vtc_data_valid;
    logic [31:0] I_vtc_data;
    logic        O_vtc_vs;
    logic        O_vtc_data_valid;
    logic [31:0] O_vtc_data;

    video_half_scaler #(.H_ACTIVE(H), .LBUF_AW(AW)) dut (
        .I_clk            (I_clk),
        .I_rst            (I_rst),
        .I_vtc_vs         (I_vtc_vs),
        .I_vtc_data_valid (I_vtc_data_valid),
        .I_vtc_data       (I_vtc_data),
        .O_vtc_vs         (O_vtc_vs),
        .O_vtc_data_valid (O_vtc_data_valid),
        .O_vtc_data       (O_vtc_data)
    );

    always #5 I_clk = ~I_clk;

    // ---------------- clock bookkeeping ----------------
    int   cyc = 0;
    int   rst_quiet = 3;
    logic vs_d1 = 1'b0;
    logic vs_d2 = 1'b0;
    always @(posedge I_clk) begin
        cyc   <= cyc + 1;
        vs_d1 <= I_vtc_vs;
        vs_d2 <= vs_d1;
        if (I_rst) rst_quiet <= 3;
        else if (rst_quiet > 0) rst_quiet <= rst_quiet - 1;
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] got_q[$];
    int          total = 0;
    int          bad = 0;
    int          n_valid = 0;
    logic [31:0] mon_e;
    int          mon_ec;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", name, got, exp, cyc);
        end
    endtask

    always @(negedge I_clk) begin
        if (O_vtc_data_valid === 1'b1) begin
            n_valid++;
            got_q.push_back(O_vtc_data);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid got=%h exp=none cyc=%0d", O_vtc_data, cyc);
            end else begin
                mon_e  = exp_q.pop_front();
                mon_ec = exp_cyc_q.pop_front();
                check("pixel", O_vtc_data, mon_e);
                check("latency_cyc", cyc, mon_ec);
            end
        end
        if (rst_quiet == 0) check("vs_delay", {31'd0, O_vtc_vs}, {31'd0, vs_d2});
    end

    // ---------------- reference model ----------------
    int          m_line;     // line index within frame, -1 while waiting for a frame start
    int          m_col;
    bit          m_discard;
    logic [31:0] m_hold;
    logic [31:0] m_even [H];  // pixels of the most recent even line, stored pairwise

    function automatic logic [31:0] avg4(logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [31:0] d);
        logic [31:0] r;
        int s;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            s = int'(a[k*8 +: 8]) + int'(b[k*8 +: 8]) + int'(c[k*8 +: 8]) + int'(d[k*8 +: 8]);
`ifdef HALF_SCALER_ROUND_EN
            s = (s + 2) / 4;
`else
            s = s / 4;
`endif
            r[k*8 +: 8] = s[7:0];
        end
        return r;
    endfunction

    function automatic void m_reset();
        m_line = -1;
        m_col = 0;
        m_discard = 0;
    endfunction

    function automatic void m_vs_rise(bit de_now);
        m_line = 0;
        m_col = 0;
        m_discard = de_now;
    endfunction

    function automatic void m_pixel(logic [31:0] p);
        if (m_line < 0 || m_discard || m_col >= H) return;
        if (m_col % 2 == 0) begin
            m_hold = p;
        end else if (m_line % 2 == 0) begin
            m_even[m_col-1] = m_hold;
            m_even[m_col]   = p;
        end else begin
            exp_q.push_back(avg4(m_even[m_col-1], m_even[m_col], m_hold, p));
            exp_cyc_q.push_back(cyc + 2);
        end
        m_col++;
    endfunction

    function automatic void m_line_end();
        m_col = 0;
        if (m_discard) m_discard = 0;
        else if (m_line >= 0) m_line++;
    endfunction

    // ---------------- drivers ----------------
    logic [31:0] pix_buf [H+4];

    task automatic drive(input logic de, input logic vs, input logic [31:0] d);
        @(posedge I_clk);
        #1;
        I_vtc_data_valid = de;
        I_vtc_vs = vs;
        I_vtc_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < H + 4; i++) pix_buf[i] = $urandom();
    endtask

    task automatic fill_const(input logic [31:0] v);
        for (int i = 0; i < H + 4; i++) pix_buf[i] = v;
    endtask

    // gap == 0 leaves DE high so the caller can continue the line
    task automatic drive_line(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, pix_buf[i]);
            m_pixel(pix_buf[i]);
        end
        for (int g = 0; g < gap; g++) begin
            drive(1'b0, 1'b0, 32'h0);
            if (g == 0) m_line_end();
        end
    endtask

    task automatic frame_start();
        drive(1'b0, 1'b1, 32'h0);
        m_vs_rise(1'b0);
        drive(1'b0, 1'b1, 32'h0);
        idle(2);
    endtask

    // ---------------- stimulus ----------------
    int nv0;
    int n_bad_px;
    logic [31:0] p;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        I_rst = 1'b1;
        I_vtc_vs = 1'b0;
        I_vtc_data_valid = 1'b0;
        I_vtc_data = 32'h0;
        m_reset();
        repeat (3) @(posedge I_clk);
        @(negedge I_clk);
        check("rst_valid", {31'd0, O_vtc_data_valid}, 32'd0);
        check("rst_data", O_vtc_data, 32'd0);
        check("rst_vs", {31'd0, O_vtc_vs}, 32'd0);
        @(posedge I_clk);
        #1 I_rst = 1'b0;
        idle(2);

        // Constant frame: every output pixel equals the input colour.
        got_q.delete();
        nv0 = n_valid;
        frame_start();
        fill_const(32'h00336699);
        for (int l = 0; l < 36; l++) drive_line(H, 3);
        idle(4);
        check("const_count", n_valid - nv0, 18 * H / 2);
        n_bad_px = 0;
        foreach (got_q[i]) if (got_q[i] !== 32'h00336699) n_bad_px++;
        check("const_pixels", n_bad_px, 0);

        // Hand-picked 2x2 blocks: small R sum and full-scale white.
        got_q.delete();
        nv0 = n_valid;
        frame_start();
        fill_rand();
        pix_buf[0] = 32'h00010000;
        pix_buf[1] = 32'h00020000;
        pix_buf[2] = 32'h00FFFFFF;
        pix_buf[3] = 32'hABFFFFFF;
        drive_line(H, 2);
        fill_rand();
        pix_buf[0] = 32'h00020000;
        pix_buf[1] = 32'h5A020000;
        pix_buf[2] = 32'hFFFFFFFF;
        pix_buf[3] = 32'h00FFFFFF;
        drive_line(H, 1);
        idle(4);
        check("block_count", n_valid - nv0, H / 2);
        if (got_q.size() >= 2) begin
`ifdef HALF_SCALER_ROUND_EN
            check("block_r_round", {24'd0, got_q[0][23:16]}, 32'd2);
`else
            check("block_r_trunc", {24'd0, got_q[0][23:16]}, 32'd1);
`endif
            check("block_white", got_q[1], 32'h00FFFFFF);
        end

        // Over-long lines, a short odd-length even line, and 1-clock DE gaps.
        nv0 = n_valid;
        frame_start();
        fill_rand(); drive_line(H + 1, 1);
        fill_rand(); drive_line(H, 1);
        fill_rand(); drive_line(H + 1, 1);
        fill_rand(); drive_line(H + 1, 2);
        fill_rand(); drive_line(7, 1);
        fill_rand(); drive_line(H, 3);
        idle(3);
        check("overlong_count", n_valid - nv0, 3 * H / 2);

        // Frame start in the middle of an odd line.
        frame_start();
        fill_rand(); drive_line(H, 3);
        fill_rand(); drive_line(40, 0);
        p = $urandom();
        drive(1'b1, 1'b1, p);
        m_vs_rise(1'b1);
        p = $urandom();
        drive(1'b1, 1'b1, p);
        m_pixel(p);
        for (int i = 0; i < 8; i++) begin
            p = $urandom();
            drive(1'b1, 1'b0, p);
            m_pixel(p);
        end
        nv0 = n_valid;
        idle(1);
        m_line_end();
        idle(2);
        fill_rand(); drive_line(H, 3);
        idle(2);
        check("vs_abort_quiet", n_valid - nv0, 0);
        fill_rand(); drive_line(H, 3);
        idle(3);

        // Randomised frames with ragged line lengths and gaps.
        for (int f = 0; f < 2; f++) begin
            frame_start();
            for (int l = 0; l < 10; l++) begin
                fill_rand();
                drive_line($urandom_range(1, H + 2), $urandom_range(1, 4));
            end
            idle(3);
        end

        // Reset in the middle of an odd line.
        frame_start();
        fill_rand(); drive_line(H, 2);
        fill_rand(); drive_line(41, 0);
        @(posedge I_clk);
        #1;
        I_rst = 1'b1;
        I_vtc_data = $urandom();
        m_reset();
        @(posedge I_clk);
        #1;
        I_rst = 1'b0;
        I_vtc_data = $urandom();
        @(negedge I_clk);
        check("midrst_valid", {31'd0, O_vtc_data_valid}, 32'd0);
        check("midrst_data", O_vtc_data, 32'd0);
        nv0 = n_valid;
        fill_rand(); drive_line(10, 2);
        fill_rand(); drive_line(H, 2);
        fill_rand(); drive_line(H, 3);
        check("post_rst_quiet", n_valid - nv0, 0);
        nv0 = n_valid;
        frame_start();
        for (int l = 0; l < 6; l++) begin
            fill_rand();
            drive_line(H, 2);
        end
        idle(5);
        check("post_rst_count", n_valid - nv0, 3 * H / 2);
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
